// File: rtl/fetch_pair.sv
// fetch_pair
// Dual-issue fetch stage feeding the dependency-check stage. Every cycle it
// reads two consecutive instruction words at the current PC, looks both up in
// a 16-entry direct-mapped branch target buffer with 2-bit saturating
// counters, and registers the pair into the F/C pipeline register.
//
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   imem_addr1/2   (out, 11)     word addresses of pc and pc+4
//   imem_data1/2   (in, 32)      combinational instruction words
//   stall          (in)          hold PC and F/C register
//   advance_one    (in)          check stage deferred slot 2, advance by 4
//   fail_predictD/E, redirect_pcD/E  redirects from D and E stages
//   upd_en, upd_pc, upd_target, upd_taken  BTB update from E
//   pc1_out/pc2_out, inst1_out/inst2_out, state1_out/state2_out  F/C register
//   hit_predict1   (out)         slot 1 predicted taken, slot 2 squashed

module fetch_pair #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [10:0] imem_addr1,
    output logic [10:0] imem_addr2,
    input  logic [31:0] imem_data1,
    input  logic [31:0] imem_data2,
    input  logic        stall,
    input  logic        advance_one,
    input  logic        fail_predictD,
    input  logic        fail_predictE,
    input  logic [12:0] redirect_pcD,
    input  logic [12:0] redirect_pcE,
    input  logic        upd_en,
    input  logic [12:0] upd_pc,
    input  logic [12:0] upd_target,
    input  logic        upd_taken,
    output logic [12:0] pc1_out,
    output logic [12:0] pc2_out,
    output logic [31:0] inst1_out,
    output logic [31:0] inst2_out,
    output logic [1:0]  state1_out,
    output logic [1:0]  state2_out,
    output logic        hit_predict1
);

    logic [12:0] pc;
    logic [12:0] pc_plus4;
    logic [12:0] pc_plus8;
    logic [12:0] next_pc;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [6:0]  btb_tag    [BTB_ENTRIES];
    logic [12:0] btb_target [BTB_ENTRIES];
    logic [1:0]  btb_ctr    [BTB_ENTRIES];

    logic [3:0]  idx1, idx2, upd_idx;
    logic        hit1, hit2, upd_hit;
    logic        taken1, taken2;
    logic [1:0]  state1, state2;
    logic        redirect;

    // 13-bit arithmetic wraps naturally, so 13'h1FFC pairs with 13'h0000.
    assign pc_plus4   = pc + 13'd4;
    assign pc_plus8   = pc + 13'd8;
    assign imem_addr1 = pc[12:2];
    assign imem_addr2 = pc_plus4[12:2];

    assign idx1    = pc[5:2];
    assign idx2    = pc_plus4[5:2];
    assign upd_idx = upd_pc[5:2];

    // Lookups read the array contents before this edge's update, so a
    // same-cycle update to the same index is seen only from the next cycle.
    assign hit1    = btb_valid[idx1] && (btb_tag[idx1] == pc[12:6]);
    assign hit2    = btb_valid[idx2] && (btb_tag[idx2] == pc_plus4[12:6]);
    assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_pc[12:6]);

    assign taken1 = hit1 && btb_ctr[idx1][1];
    assign taken2 = hit2 && btb_ctr[idx2][1];
    assign state1 = hit1 ? btb_ctr[idx1] : 2'b01;
    assign state2 = hit2 ? btb_ctr[idx2] : 2'b01;

    // D-stage redirect loses to a stall; E-stage redirect never does.
    assign redirect = fail_predictE || (fail_predictD && !stall);

    always_comb begin
        next_pc = pc_plus8;
        if (fail_predictE)
            next_pc = redirect_pcE;
        else if (fail_predictD && !stall)
            next_pc = redirect_pcD;
        else if (stall)
            next_pc = pc;
        else if (taken1)
            next_pc = btb_target[idx1];
        else if (taken2)
            next_pc = btb_target[idx2];
        else if (advance_one)
            next_pc = pc_plus4;
    end

    // PC and F/C register. A redirect inserts a bubble; a slot 1 prediction
    // squashes slot 2 so the check stage never issues past the branch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc           <= '0;
            pc1_out      <= '0;
            pc2_out      <= '0;
            inst1_out    <= '0;
            inst2_out    <= '0;
            state1_out   <= '0;
            state2_out   <= '0;
            hit_predict1 <= 1'b0;
        end else begin
            pc <= next_pc;
            if (redirect) begin
                pc1_out      <= '0;
                pc2_out      <= '0;
                inst1_out    <= '0;
                inst2_out    <= '0;
                state1_out   <= '0;
                state2_out   <= '0;
                hit_predict1 <= 1'b0;
            end else if (!stall) begin
                pc1_out    <= pc;
                inst1_out  <= imem_data1;
                state1_out <= state1;
                if (taken1) begin
                    pc2_out      <= '0;
                    inst2_out    <= '0;
                    state2_out   <= '0;
                    hit_predict1 <= 1'b1;
                end else begin
                    pc2_out      <= pc_plus4;
                    inst2_out    <= imem_data2;
                    state2_out   <= state2;
                    hit_predict1 <= 1'b0;
                end
            end
        end
    end

    // Valid bits are the only BTB state that needs a reset value; an entry
    // becomes valid only through a taken update (hit or allocation).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            btb_valid <= '0;
        else if (upd_en && upd_taken)
            btb_valid[upd_idx] <= 1'b1;
    end

    // Tag, target and counter storage. Writes are suppressed while RST is
    // high so an update presented during reset is discarded.
    always_ff @(posedge CLK) begin
        if (!RST && upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    btb_target[upd_idx] <= upd_target;
                    if (btb_ctr[upd_idx] != 2'b11)
                        btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                end else if (btb_ctr[upd_idx] != 2'b00) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_tag[upd_idx]    <= upd_pc[12:6];
                btb_target[upd_idx] <= upd_target;
                btb_ctr[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pair.sv
// tb_fetch_pair
// Self-checking bench for fetch_pair: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch stage.

module tb_fetch_pair;

    logic        CLK = 1'b0;
    logic        RST;
    logic [10:0] imem_addr1, imem_addr2;
    logic [31:0] imem_data1, imem_data2;
    logic        stall, advance_one, fail_predictD, fail_predictE;
    logic [12:0] redirect_pcD, redirect_pcE;
    logic        upd_en, upd_taken;
    logic [12:0] upd_pc, upd_target;
    logic [12:0] pc1_out, pc2_out;
    logic [31:0] inst1_out, inst2_out;
    logic [1:0]  state1_out, state2_out;
    logic        hit_predict1;

    fetch_pair dut (
        .CLK(CLK), .RST(RST),
        .imem_addr1(imem_addr1), .imem_addr2(imem_addr2),
        .imem_data1(imem_data1), .imem_data2(imem_data2),
        .stall(stall), .advance_one(advance_one),
        .fail_predictD(fail_predictD), .fail_predictE(fail_predictE),
        .redirect_pcD(redirect_pcD), .redirect_pcE(redirect_pcE),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken),
        .pc1_out(pc1_out), .pc2_out(pc2_out),
        .inst1_out(inst1_out), .inst2_out(inst2_out),
        .state1_out(state1_out), .state2_out(state2_out),
        .hit_predict1(hit_predict1)
    );

    always #5 CLK = ~CLK;

    // Instruction memory content is a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return {a, 5'h15, ~a, 5'h0A};
    endfunction

    assign imem_data1 = mem_word(imem_addr1);
    assign imem_data2 = mem_word(imem_addr2);

    int num_checks = 0;
    int num_errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Behavioural model: BTB entries keyed by index, confidence as an int.
    typedef struct {
        bit        valid;
        bit [6:0]  tag;
        bit [12:0] target;
        int        conf;
    } btb_entry_t;

    btb_entry_t  model_btb [16];
    bit [12:0]   model_pc;
    bit [12:0]   exp_pc1, exp_pc2;
    bit [31:0]   exp_inst1, exp_inst2;
    bit [1:0]    exp_st1, exp_st2;
    bit          exp_hit;

    task automatic model_reset();
        model_pc = '0;
        exp_pc1 = '0; exp_pc2 = '0; exp_inst1 = '0; exp_inst2 = '0;
        exp_st1 = '0; exp_st2 = '0; exp_hit = 1'b0;
        for (int i = 0; i < 16; i++) model_btb[i].valid = 1'b0;
    endtask

    task automatic model_lookup(input bit [12:0] p, output bit taken,
                                output bit [1:0] state, output bit [12:0] tgt);
        int i;
        i = int'(p[5:2]);
        taken = 1'b0; state = 2'b01; tgt = '0;
        if (model_btb[i].valid && model_btb[i].tag == p[12:6]) begin
            state = 2'(model_btb[i].conf);
            taken = model_btb[i].conf >= 2;
            tgt   = model_btb[i].target;
        end
    endtask

    task automatic model_update(input bit [12:0] p, input bit [12:0] t, input bit tk);
        int i;
        i = int'(p[5:2]);
        if (model_btb[i].valid && model_btb[i].tag == p[12:6]) begin
            if (tk) begin
                model_btb[i].conf   = (model_btb[i].conf < 3) ? model_btb[i].conf + 1 : 3;
                model_btb[i].target = t;
            end else begin
                model_btb[i].conf = (model_btb[i].conf > 0) ? model_btb[i].conf - 1 : 0;
            end
        end else if (tk) begin
            model_btb[i].valid  = 1'b1;
            model_btb[i].tag    = p[12:6];
            model_btb[i].target = t;
            model_btb[i].conf   = 2;
        end
    endtask

    task automatic check_all();
        checkOutput("pc1_out",      32'(pc1_out),      32'(exp_pc1));
        checkOutput("pc2_out",      32'(pc2_out),      32'(exp_pc2));
        checkOutput("inst1_out",    inst1_out,         exp_inst1);
        checkOutput("inst2_out",    inst2_out,         exp_inst2);
        checkOutput("state1_out",   32'(state1_out),   32'(exp_st1));
        checkOutput("state2_out",   32'(state2_out),   32'(exp_st2));
        checkOutput("hit_predict1", 32'(hit_predict1), 32'(exp_hit));
        checkOutput("imem_addr1",   32'(imem_addr1),   32'(model_pc[12:2]));
        checkOutput("imem_addr2",   32'(imem_addr2),   32'(model_pc[12:2] + 11'd1));
    endtask

    // Drives one cycle of inputs (called at posedge+1), advances the model,
    // waits for the edge and checks every output.
    task automatic applyStimulus(input bit st, input bit adv, input bit fpd,
                                 input bit fpe, input bit [12:0] rd,
                                 input bit [12:0] re, input bit ue,
                                 input bit [12:0] up, input bit [12:0] ut,
                                 input bit utk);
        bit        t1, t2;
        bit [1:0]  s1, s2;
        bit [12:0] g1, g2, p2;
        stall = st; advance_one = adv; fail_predictD = fpd; fail_predictE = fpe;
        redirect_pcD = rd; redirect_pcE = re;
        upd_en = ue; upd_pc = up; upd_target = ut; upd_taken = utk;

        p2 = model_pc + 13'd4;
        model_lookup(model_pc, t1, s1, g1);
        model_lookup(p2, t2, s2, g2);
        if (fpe || (fpd && !st)) begin
            exp_pc1 = '0; exp_pc2 = '0; exp_inst1 = '0; exp_inst2 = '0;
            exp_st1 = '0; exp_st2 = '0; exp_hit = 1'b0;
            model_pc = fpe ? re : rd;
        end else if (!st) begin
            exp_pc1   = model_pc;
            exp_inst1 = mem_word(model_pc[12:2]);
            exp_st1   = s1;
            exp_hit   = t1;
            exp_pc2   = t1 ? 13'd0 : p2;
            exp_inst2 = t1 ? 32'd0 : mem_word(p2[12:2]);
            exp_st2   = t1 ? 2'd0 : s2;
            if (t1)       model_pc = g1;
            else if (t2)  model_pc = g2;
            else if (adv) model_pc = p2;
            else          model_pc = model_pc + 13'd8;
        end
        if (ue) model_update(up, ut, utk);

        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 13'd0, 13'd0, 0, 13'd0, 13'd0, 0);
    endtask

    task automatic redirect_e(input bit [12:0] target);
        applyStimulus(0, 0, 0, 1, 13'd0, target, 0, 13'd0, 13'd0, 0);
    endtask

    task automatic btb_update(input bit [12:0] p, input bit [12:0] t, input bit tk);
        applyStimulus(0, 0, 0, 0, 13'd0, 13'd0, 1, p, t, tk);
    endtask

    // Asserts reset with a redirect and update pending, which must both be
    // discarded, and checks that outputs clear before any clock edge.
    task automatic doReset();
        RST = 1'b1;
        fail_predictE = 1'b1; redirect_pcE = 13'h0300;
        upd_en = 1'b1; upd_pc = 13'h0018; upd_target = 13'h0400; upd_taken = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge CLK);
        #1;
        check_all();
        RST = 1'b0;
        stall = 0; advance_one = 0; fail_predictD = 0; fail_predictE = 0;
        redirect_pcD = '0; redirect_pcE = '0;
        upd_en = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
    endtask

    initial begin
        doReset();

        // Free run from reset, then wrap from the top of the address space.
        idle(1);
        checkOutput("first_pc1", 32'(pc1_out), 32'h0);
        checkOutput("first_pc2", 32'(pc2_out), 32'h4);
        checkOutput("first_state1", 32'(state1_out), 32'h1);
        idle(1);
        checkOutput("second_pc1", 32'(pc1_out), 32'h8);
        redirect_e(13'h1FF0);
        idle(2);
        checkOutput("wrap_pc2", 32'(pc2_out), 32'h1FFC);
        idle(1);
        checkOutput("wrap_next_pc1", 32'(pc1_out), 32'h0);
        checkOutput("wrap_next_pc2", 32'(pc2_out), 32'h4);

        // Slot 1 predicted taken.
        btb_update(13'h0010, 13'h0040, 1);
        redirect_e(13'h0010);
        checkOutput("bubble_pc1", 32'(pc1_out), 32'h0);
        idle(1);
        checkOutput("s1_hit", 32'(hit_predict1), 32'h1);
        checkOutput("s1_pc2_zero", 32'(pc2_out), 32'h0);
        checkOutput("s1_state1", 32'(state1_out), 32'h2);
        idle(1);
        checkOutput("s1_target_pc1", 32'(pc1_out), 32'h40);
        checkOutput("s1_target_pc2", 32'(pc2_out), 32'h44);

        // Mid-stream reset clears the BTB; then slot 2 predicted taken.
        doReset();
        btb_update(13'h0014, 13'h0080, 1);
        redirect_e(13'h0010);
        idle(1);
        checkOutput("s2_pc1", 32'(pc1_out), 32'h10);
        checkOutput("s2_pc2", 32'(pc2_out), 32'h14);
        checkOutput("s2_state1_miss", 32'(state1_out), 32'h1);
        checkOutput("s2_state2", 32'(state2_out), 32'h2);
        checkOutput("s2_hit", 32'(hit_predict1), 32'h0);
        idle(1);
        checkOutput("s2_target_pc1", 32'(pc1_out), 32'h80);

        // Counter saturation in both directions, and a not-taken miss.
        for (int i = 0; i < 3; i++) btb_update(13'h0030, 13'h0060, 1);
        redirect_e(13'h0030);
        idle(1);
        checkOutput("sat_up_state", 32'(state1_out), 32'h3);
        for (int i = 0; i < 4; i++) btb_update(13'h0030, 13'h0060, 0);
        redirect_e(13'h0030);
        idle(1);
        checkOutput("sat_down_state", 32'(state1_out), 32'h0);
        checkOutput("sat_down_hit", 32'(hit_predict1), 32'h0);
        idle(1);
        checkOutput("sat_down_seq", 32'(pc1_out), 32'h38);
        btb_update(13'h0050, 13'h0123, 0);
        redirect_e(13'h0050);
        idle(1);
        checkOutput("miss_nt_state", 32'(state1_out), 32'h1);

        // Stall masks the D redirect, E redirect overrides the stall.
        applyStimulus(1, 0, 1, 0, 13'h0100, 13'd0, 0, 13'd0, 13'd0, 0);
        checkOutput("stall_hold_pc1", 32'(pc1_out), 32'h50);
        applyStimulus(1, 0, 1, 1, 13'h0100, 13'h0200, 0, 13'd0, 13'd0, 0);
        checkOutput("stall_e_bubble", 32'(pc1_out), 32'h0);
        idle(1);
        checkOutput("stall_e_pc1", 32'(pc1_out), 32'h200);
        checkOutput("stall_e_pc2", 32'(pc2_out), 32'h204);

        // advance_one moves by a single word.
        redirect_e(13'h0020);
        applyStimulus(0, 1, 0, 0, 13'd0, 13'd0, 0, 13'd0, 13'd0, 0);
        idle(1);
        checkOutput("adv_pc1", 32'(pc1_out), 32'h24);
        checkOutput("adv_pc2", 32'(pc2_out), 32'h28);

        // Random traffic within a small address window so tags alias.
        for (int n = 0; n < 600; n++) begin
            bit [12:0] rd, re, up, ut;
            rd = {7'($urandom_range(0, 2)), 4'($urandom), 2'b00};
            re = {7'($urandom_range(0, 2)), 4'($urandom), 2'b00};
            up = {7'($urandom_range(0, 2)), 4'($urandom), 2'b00};
            ut = {7'($urandom_range(0, 2)), 4'($urandom), 2'b00};
            if ($urandom_range(0, 99) == 0)
                doReset();
            else
                applyStimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
                              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 7,
                              rd, re, $urandom_range(0, 99) < 35, up, ut,
                              $urandom_range(0, 99) < 60);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
